// File: rtl/mul8_seq_ctrl.sv
// mul8_seq_ctrl: unsigned 8x8 multiply built from one 4x4 array multiplier, used
// once per cycle over four cycles. Each nibble partial product is shifted into place
// and accumulated into a 16-bit register.
//
// This file also holds csa_multiplier, the 4x4 multiplier the controller instantiates.
//
// Ports (mul8_seq_ctrl):
//   clk, rst_n          clock, asynchronous active-low reset
//   clr                 synchronous abort back to idle (highest priority)
//   in_valid/in_ready   operand handshake; in_ready high only while idle
//   a, b                8-bit unsigned operands, latched on accept
//   out_valid/out_ready result handshake; out_valid high only while done
//   product             16-bit result, updated only when an operation completes
//   busy                high while multiplying or holding a result

// csa_multiplier: combinational 4x4 unsigned multiplier. The four partial-product rows
// are reduced with two carry-save rows, then one carry-propagate add.
// Ports: i_x, i_y (4-bit operands), o_p (8-bit product).
module csa_multiplier (
  input  logic [3:0] i_x,
  input  logic [3:0] i_y,
  output logic [7:0] o_p
);

  logic [7:0] w_pp0, w_pp1, w_pp2, w_pp3;
  logic [7:0] w_s1, w_c1, w_s2, w_c2;

  assign w_pp0 = {4'b0, i_x & {4{i_y[0]}}};
  assign w_pp1 = {3'b0, i_x & {4{i_y[1]}}, 1'b0};
  assign w_pp2 = {2'b0, i_x & {4{i_y[2]}}, 2'b0};
  assign w_pp3 = {1'b0, i_x & {4{i_y[3]}}, 3'b0};

  // Carry vectors cannot exceed the final product (<= 225), so no bit leaves the byte.
  assign w_s1 = w_pp0 ^ w_pp1 ^ w_pp2;
  assign w_c1 = {((w_pp0[6:0] & w_pp1[6:0]) | (w_pp0[6:0] & w_pp2[6:0]) |
                  (w_pp1[6:0] & w_pp2[6:0])), 1'b0};
  assign w_s2 = w_s1 ^ w_c1 ^ w_pp3;
  assign w_c2 = {((w_s1[6:0] & w_c1[6:0]) | (w_s1[6:0] & w_pp3[6:0]) |
                  (w_c1[6:0] & w_pp3[6:0])), 1'b0};
  assign o_p  = w_s2 + w_c2;

endmodule

module mul8_seq_ctrl #(
  parameter int unsigned SKIP_ZERO = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [1:0]  r_step;
  logic [15:0] r_acc;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [15:0] r_product;

  logic        w_accept;
  logic        w_zero;
  logic [3:0]  w_mx;
  logic [3:0]  w_my;
  logic [7:0]  w_pp;
  logic [15:0] w_pp_sh;
  logic [15:0] w_sum;

  assign w_accept = in_valid && (r_state == StIdle);
  assign w_zero   = (SKIP_ZERO != 0) && ((a == 8'h00) || (b == 8'h00));

  // step[1] picks the a nibble, step[0] the b nibble; only latched operands feed the mux.
  assign w_mx = r_step[1] ? r_a[7:4] : r_a[3:0];
  assign w_my = r_step[0] ? r_b[7:4] : r_b[3:0];

  csa_multiplier u_mul (
    .i_x (w_mx),
    .i_y (w_my),
    .o_p (w_pp)
  );

  always_comb begin
    w_pp_sh = 16'h0000;
    case (r_step)
      2'd0:    w_pp_sh = {8'h00, w_pp};
      2'd1,
      2'd2:    w_pp_sh = {4'h0, w_pp, 4'h0};
      default: w_pp_sh = {w_pp, 8'h00};
    endcase
  end

  // Final sum peaks at 0xFE01, so the 16-bit add never wraps.
  assign w_sum = r_acc + w_pp_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (clr) begin
      w_state_next = StIdle;
    end else begin
      case (r_state)
        StIdle: if (w_accept) w_state_next = w_zero ? StDone : StMul;
        StMul:  if (r_step == 2'd3) w_state_next = StDone;
        StDone: if (out_ready) w_state_next = StIdle;
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step    <= 2'd0;
      r_acc     <= 16'h0000;
      r_a       <= 8'h00;
      r_b       <= 8'h00;
      r_product <= 16'h0000;
    end else if (clr) begin
      r_step <= 2'd0;
      r_acc  <= 16'h0000;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_a    <= a;
            r_b    <= b;
            r_acc  <= 16'h0000;
            r_step <= 2'd0;
            if (w_zero) r_product <= 16'h0000;
          end
        end
        StMul: begin
          r_acc  <= w_sum;
          r_step <= r_step + 2'd1;
          if (r_step == 2'd3) r_product <= w_sum;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StDone);
  assign busy      = (r_state != StIdle);
  assign product   = r_product;

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Testbench for mul8_seq_ctrl. The driver pushes the expected product into a queue
// whenever an operand pair is accepted; a separate monitor pops and compares whenever
// the DUT hands a result over. A second instance with SKIP_ZERO=1 covers the bypass.
module tb_mul8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, clr, in_valid, out_ready;
  logic [7:0]  a, b;
  logic        in_ready, out_valid, busy;
  logic [15:0] product;

  logic        z_in_valid, z_in_ready, z_out_valid, z_busy;
  logic [7:0]  z_a, z_b;
  logic [15:0] z_product;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];
  bit          rand_rdy = 1'b0;

  always #5 clk = ~clk;

  mul8_seq_ctrl #(.SKIP_ZERO(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  mul8_seq_ctrl #(.SKIP_ZERO(1)) dut_sz (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (1'b0),
    .in_valid  (z_in_valid),
    .in_ready  (z_in_ready),
    .a         (z_a),
    .b         (z_b),
    .out_valid (z_out_valid),
    .out_ready (1'b1),
    .product   (z_product),
    .busy      (z_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Monitor: a result transfers on the next rising edge when both are high.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got 0x%0h expected no output", product);
      end else begin
        chk("product", {16'h0, product}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  // Random out_ready stalls during the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 9) < 7);
    end
  end

  // Called 1 time unit after a rising edge; returns 1 time unit after the accept edge.
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib);
    bit ok = 1'b0;
    int n  = 0;
    a = ia;
    b = ib;
    in_valid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (in_ready && !clr && rst_n) begin
        exp_q.push_back({8'h00, ia} * {8'h00, ib});
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    // Operands change after accept; the DUT must not care.
    a = 8'($urandom);
    b = 8'($urandom);
    if (!ok) timeout_fail("accept");
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (!out_valid && cycles < 50);
  endtask

  task automatic directed(input string name, input logic [7:0] ia, input logic [7:0] ib);
    int lat;
    issue(ia, ib);
    wait_out(lat);
    chk({name, "_latency"}, lat, 4);
    @(posedge clk);
    #1;
    chk({name, "_back_idle"}, {31'h0, in_ready}, 1);
  endtask

  initial begin
    int lat;
    int seen;
    logic [15:0] held;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = 8'h00; b = 8'h00;
    z_in_valid = 1'b0; z_a = 8'h00; z_b = 8'h00;

    #12;
    chk("rst_out_valid", {31'h0, out_valid}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_product", {16'h0, product}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", {31'h0, in_ready}, 1);

    // 0xFF*0xFF = 0xFE01, 0x12*0x34 = 0x03A8, 0x80*0x02 = 0x0100
    directed("ff_ff", 8'hFF, 8'hFF);
    directed("12_34", 8'h12, 8'h34);
    directed("80_02", 8'h80, 8'h02);

    // Hold in DONE for 10 cycles: 0x0F*0x0F = 0x00E1
    out_ready = 1'b0;
    issue(8'h0F, 8'h0F);
    wait_out(lat);
    chk("stall_latency", lat, 4);
    in_valid = 1'b1;
    a = 8'h77;
    b = 8'h77;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", {31'h0, out_valid}, 1);
      chk("stall_product", {16'h0, product}, 32'h00E1);
      chk("stall_in_ready", {31'h0, in_ready}, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_release_idle", {31'h0, in_ready}, 1);

    // Zero operand: bypass instance completes in one cycle, plain instance in four.
    z_a = 8'h00; z_b = 8'h7F; z_in_valid = 1'b1;
    @(posedge clk);
    #1;
    z_in_valid = 1'b0;
    chk("sz_valid_1cyc", {31'h0, z_out_valid}, 1);
    chk("sz_product", {16'h0, z_product}, 0);
    @(posedge clk);
    #1;
    chk("sz_back_idle", {31'h0, z_in_ready}, 1);
    z_a = 8'h03; z_b = 8'h05; z_in_valid = 1'b1;
    @(posedge clk);
    #1;
    z_in_valid = 1'b0;
    lat = 0;
    while (!z_out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("sz_nonzero_latency", lat, 4);
    chk("sz_nonzero_product", {16'h0, z_product}, 32'h000F);
    directed("zero_noskip", 8'h00, 8'h7F);

    // Reset during step2 of 0xAB*0xCD
    issue(8'hAB, 8'hCD);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_out_valid", {31'h0, out_valid}, 0);
    chk("midrst_busy", {31'h0, busy}, 0);
    chk("midrst_product", {16'h0, product}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    directed("03_05", 8'h03, 8'h05);

    // clr at step1 of 0x11*0x11; product keeps 0x000F
    issue(8'h11, 8'h11);
    @(posedge clk);
    #1;
    clr = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("clr_idle", {31'h0, in_ready}, 1);
    chk("clr_busy", {31'h0, busy}, 0);
    chk("clr_product", {16'h0, product}, 32'h000F);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("clr_no_out_valid", seen, 0);

    // clr with in_valid in IDLE: nothing accepted
    clr = 1'b1; in_valid = 1'b1; a = 8'h05; b = 8'h05;
    @(posedge clk);
    #1;
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_blocks_accept", {31'h0, busy}, 0);
    held = product;
    chk("clr_idle_product", {16'h0, held}, 32'h000F);

    // Random operands with random idle gaps and sink stalls
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      int gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        #1;
      end
      issue(8'($urandom), 8'($urandom));
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    while (exp_q.size() != 0 && seen < 50) begin
      @(posedge clk);
      #1;
      seen++;
    end
    chk("random_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
